// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory master: access-size
// encodings, the bridge state machine states and the byte-strobe patterns.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Strobes are LSB-aligned; the slave handles the address offset itself.
  localparam logic [3:0] STB_BYTE = 4'b0001;
  localparam logic [3:0] STB_HALF = 4'b0011;
  localparam logic [3:0] STB_WORD = 4'b1111;

  // Strobe pattern for a legal access size; illegal size never reaches the bus.
  function automatic logic [3:0] size_to_stb(input logic [1:0] sz);
    logic [3:0] stb;
    case (sz)
      SZ_BYTE: stb = STB_BYTE;
      SZ_HALF: stb = STB_HALF;
      SZ_WORD: stb = STB_WORD;
      default: stb = 4'b0000;
    endcase
    return stb;
  endfunction

endpackage

// File: rtl/apb_load_ext.sv
// Load-data extension: picks the byte/half/word from LSB-aligned read data
// and sign- or zero-extends it to 32 bits.
module apb_load_ext
  import apb_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic fill_b;
  logic fill_h;

  // Fill bit is the top bit of the accessed field, forced to 0 for unsigned.
  assign fill_b = ~is_unsigned & raw[7];
  assign fill_h = ~is_unsigned & raw[15];

  // Select the field width and replicate the fill bit above it.
  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{fill_b}}, raw[7:0]};
      SZ_HALF: ext = {{16{fill_h}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/apb_mem_master.sv
// APB memory master: turns one CPU load/store request into one APB transfer
// (SETUP then ACCESS until pready), extends load data and returns a single
// registered response pulse. Slave errors, wait-state timeout and illegal
// sizes all come back as rsp_err with zero data.
module apb_mem_master
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  prst,
  // CPU side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB side
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr
);

  // Last ACCESS cycle allowed before the transfer is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  err_q;
  logic [7:0]            cnt_q;
  logic [DATA_WIDTH-1:0] ext_data;

  // One-cycle control strobes from the FSM to the datapath.
  logic accept;    // legal request taken in IDLE
  logic reject;    // illegal size taken in IDLE
  logic done_ok;   // pready seen in ACCESS
  logic done_err;  // perr alone or timeout in ACCESS

  apb_load_ext u_ext (
    .size        (size_q),
    .is_unsigned (uns_q),
    .raw         (rd_q),
    .ext         (ext_data)
  );

  // State register; reset drops psel/penable at once since they decode state.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and bus handshake decode.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_size == SZ_ILL) begin
            reject  = 1'b1;
            state_d = RESP;
          end else begin
            accept  = 1'b1;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready wins over a lone perr, which wins over the timeout.
        if (pready) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (perr || (cnt_q == TO_LAST)) begin
          done_err = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture: APB address/data/direction/strobes stay put until the
  // next accepted request, so they are stable through SETUP and ACCESS.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      paddr  <= '0;
      pdata  <= '0;
      pwrite <= 1'b0;
      pstb   <= 4'b0000;
      size_q <= SZ_BYTE;
      uns_q  <= 1'b0;
    end else if (accept) begin
      paddr  <= req_addr;
      pdata  <= req_wdata;
      pwrite <= req_write;
      pstb   <= size_to_stb(req_size);
      size_q <= req_size;
      uns_q  <= req_unsigned;
    end
  end

  // Wait-state counter: counts ACCESS cycles, cleared once the response goes out.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst)                    cnt_q <= 8'd0;
    else if (state_q == ACCESS)  cnt_q <= cnt_q + 8'd1;
    else if (state_q == RESP)    cnt_q <= 8'd0;
  end

  // Completion status: raw read data and the error flag for the response.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (reject || done_err) begin
      err_q <= 1'b1;
    end else if (done_ok) begin
      rd_q  <= prdata;
      err_q <= perr;
    end
  end

  // Response register: one pulse in the cycle after RESP; data is zero for
  // stores, errors, and whenever no response is being signalled.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (state_q == RESP) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err_q;
      rsp_rdata <= (err_q || pwrite) ? '0 : ext_data;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_apb_mem_master.sv
// Bench for apb_mem_master: directed requests against a scripted APB slave,
// a queue-based response/bus model and a per-cycle compare process.
module tb_apb_mem_master;

  localparam int TO = 8;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        pready;
  logic        perr;

  apb_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .paddr(paddr), .pdata(pdata), .prdata(prdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb),
    .pready(pready), .perr(perr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Slave behaviour: 0 normal, 1 pready+perr, 2 perr alone, 3 never ready.
  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic write; logic [3:0] stb; } apb_t;
  typedef struct { int waits; logic [31:0] rdata; int kind; } slv_t;

  exp_t exp_q[$];
  apb_t apb_q[$];
  slv_t slv_q[$];
  int   last_rsp_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Model: strobe pattern from access size.
  function automatic logic [3:0] m_stb(input logic [1:0] sz);
    if (sz == 2'd0) return 4'h1;
    if (sz == 2'd1) return 4'h3;
    return 4'hF;
  endfunction

  // Model: load extension by arithmetic on the field value.
  function automatic logic [31:0] m_ext(input logic [1:0] sz, input logic un, input logic [31:0] d);
    longint v;
    v = longint'(d);
    if (sz == 2'd0) begin
      v = v % 256;
      if (!un && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!un && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  // Present a request (caller is at a negedge), wait for acceptance and
  // record what the bus and the response must look like.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                       input logic [1:0] sz, input logic un, input int waits,
                       input logic [31:0] rd, input int kind, output int acc);
    exp_t e;
    apb_t p;
    slv_t s;
    int guard;
    req_addr = a; req_wdata = wd; req_write = wr; req_size = sz;
    req_unsigned = un; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 200) begin
      @(negedge pclk);
      guard++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    e.err   = (sz == 2'd3) || (kind != 0);
    e.rdata = (e.err || wr) ? 32'h0 : m_ext(sz, un, rd);
    if (sz == 2'd3)     e.cyc = acc + 1;
    else if (kind == 3) e.cyc = acc + 2 + TO;
    else                e.cyc = acc + 3 + waits;
    exp_q.push_back(e);
    if (sz != 2'd3) begin
      p.addr = a; p.wdata = wd; p.write = wr; p.stb = m_stb(sz);
      apb_q.push_back(p);
      s.waits = waits; s.rdata = rd; s.kind = kind;
      slv_q.push_back(s);
    end
    @(negedge pclk);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge pclk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      fail_now("response_timeout");
      exp_q.delete();
    end
    @(negedge pclk);
  endtask

  // Scripted APB slave, driven on the falling edge.
  initial begin
    int   n;
    logic act;
    slv_t s;
    n = 0; act = 1'b0;
    s.waits = 0; s.rdata = '0; s.kind = 3;
    pready = 1'b0; perr = 1'b0; prdata = 32'hDEADBEEF;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (!act) begin
          act = 1'b1;
          n = 0;
          if (slv_q.size() > 0) s = slv_q.pop_front();
          else begin s.waits = 0; s.rdata = '0; s.kind = 3; end
        end else n++;
        pready = (s.kind == 0 || s.kind == 1) && (n == s.waits);
        perr   = (s.kind == 1 || s.kind == 2) && (n == s.waits);
        prdata = (n == s.waits) ? s.rdata : 32'hDEADBEEF;
      end else begin
        act = 1'b0;
        pready = 1'b0;
        perr = 1'b0;
      end
    end
  end

  // Compare process: responses against the model queue, bus rules every cycle.
  initial begin
    logic        pp;
    logic [31:0] pa, pd;
    logic        pw;
    logic [3:0]  ps;
    exp_t e;
    apb_t p;
    pp = 1'b0; pa = '0; pd = '0; pw = 1'b0; ps = '0;
    forever begin
      @(negedge pclk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) fail_now("spurious_rsp_valid");
        else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cycle", cyc, e.cyc);
          last_rsp_cyc = cyc;
          last_rdata = rsp_rdata;
          last_err = rsp_err;
        end
      end
      if (penable) chk("penable_without_psel", 32'(psel), 32'd1);
      if (psel && !pp) begin
        chk("setup_before_enable", 32'(penable), 32'd0);
        if (apb_q.size() == 0) fail_now("unexpected_psel");
        else begin
          p = apb_q.pop_front();
          chk("paddr", paddr, p.addr);
          chk("pdata", pdata, p.wdata);
          chk("pwrite", 32'(pwrite), 32'(p.write));
          chk("pstb", 32'(pstb), 32'(p.stb));
        end
      end
      if (psel && pp) begin
        chk("paddr_stable", paddr, pa);
        chk("pdata_stable", pdata, pd);
        chk("pwrite_stable", 32'(pwrite), 32'(pw));
        chk("pstb_stable", 32'(pstb), 32'(ps));
      end
      pp = psel; pa = paddr; pd = pdata; pw = pwrite; ps = pstb;
    end
  end

  // Global bound on simulation time.
  initial begin
    #200000;
    $display("FAIL global_watchdog (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int a1, a2;
    @(negedge pclk);
    @(negedge pclk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_pstb", 32'(pstb), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pdata", pdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    prst = 1'b0;
    @(negedge pclk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Word load, one wait state.
    issue(32'h100, 32'h0, 1'b0, 2'd2, 1'b0, 1, 32'h12345678, 0, a1);
    req_valid = 1'b0;
    wait_done();
    chk("word_load_data", last_rdata, 32'h12345678);
    chk("word_load_latency", last_rsp_cyc - a1, 32'd4);

    // Byte load from 0x103, signed then unsigned.
    issue(32'h103, 32'h0, 1'b0, 2'd0, 1'b0, 0, 32'hAABBCC80, 0, a1);
    req_valid = 1'b0;
    wait_done();
    chk("byte_signed", last_rdata, 32'hFFFFFF80);
    issue(32'h103, 32'h0, 1'b0, 2'd0, 1'b1, 0, 32'hAABBCC80, 0, a1);
    req_valid = 1'b0;
    wait_done();
    chk("byte_unsigned", last_rdata, 32'h00000080);

    // Half loads, two wait states.
    issue(32'h202, 32'h0, 1'b0, 2'd1, 1'b0, 2, 32'h55558001, 0, a1);
    req_valid = 1'b0;
    wait_done();
    chk("half_signed", last_rdata, 32'hFFFF8001);
    issue(32'h206, 32'h0, 1'b0, 2'd1, 1'b1, 2, 32'h0000FFFF, 0, a1);
    req_valid = 1'b0;
    wait_done();

    // Half store, three wait states; bus fields held until pready.
    issue(32'h202, 32'h0000BEEF, 1'b1, 2'd1, 1'b0, 3, 32'hFFFFFFFF, 0, a1);
    req_valid = 1'b0;
    wait_done();
    chk("store_rdata_zero", last_rdata, 32'h0);

    // Misaligned word store passes through unchanged.
    issue(32'h301, 32'hA5A5_5A5A, 1'b1, 2'd2, 1'b0, 0, 32'h0, 0, a1);
    req_valid = 1'b0;
    wait_done();

    // Slave error with pready, then perr alone.
    issue(32'h400, 32'h0, 1'b0, 2'd2, 1'b0, 1, 32'h11112222, 1, a1);
    req_valid = 1'b0;
    wait_done();
    chk("perr_with_pready_err", 32'(last_err), 32'd1);
    issue(32'h404, 32'h0, 1'b0, 2'd2, 1'b0, 2, 32'h33334444, 2, a1);
    req_valid = 1'b0;
    wait_done();

    // Slave never ready: abort after TO ACCESS cycles.
    issue(32'h500, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'h0, 3, a1);
    req_valid = 1'b0;
    wait_done();
    chk("timeout_latency", last_rsp_cyc - a1, 32'd10);
    chk("timeout_err", 32'(last_err), 32'd1);

    // Illegal size: error one cycle after accept, no bus activity.
    issue(32'h600, 32'h0, 1'b0, 2'd3, 1'b0, 0, 32'h0, 0, a1);
    req_valid = 1'b0;
    wait_done();
    chk("illegal_latency", last_rsp_cyc - a1, 32'd1);
    chk("illegal_err", 32'(last_err), 32'd1);

    // Reset during ACCESS: bus drops at once, request discarded.
    issue(32'h700, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'h0, 3, a1);
    req_valid = 1'b0;
    repeat (3) @(negedge pclk);
    #2 prst = 1'b1;
    #1;
    chk("async_rst_psel", 32'(psel), 32'd0);
    chk("async_rst_penable", 32'(penable), 32'd0);
    exp_q.delete();
    @(negedge pclk);
    prst = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    end
    issue(32'h704, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'hCAFE0001, 0, a1);
    req_valid = 1'b0;
    wait_done();
    chk("after_reset_data", last_rdata, 32'hCAFE0001);

    // Back-to-back with req_valid held high.
    issue(32'h800, 32'h0, 1'b0, 2'd2, 1'b0, 0, 32'hCAFEF00D, 0, a1);
    issue(32'h805, 32'h0, 1'b0, 2'd0, 1'b1, 0, 32'h000000F1, 0, a2);
    req_valid = 1'b0;
    chk("b2b_accept_after_rsp", a2, last_rsp_cyc + 1);
    chk("b2b_accept_gap", a2 - a1, 32'd4);
    wait_done();
    chk("b2b_second_data", last_rdata, 32'h000000F1);

    repeat (3) @(negedge pclk);
    if (exp_q.size() != 0 || apb_q.size() != 0) fail_now("leftover_expectations");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
